// File: rtl/bridge_arbiter.sv
// bridge_arbiter
// Shares one downstream bridge target among NUM_REQ upstream requesters.
// Requesters are granted round-robin in IDLE. One transaction is in flight
// at a time. For reads, the target data is sampled READ_LATENCY cycles after
// out_rd and handed back to the requester that won the grant.
module bridge_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ-1:0]            req_rd,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] req_rd_data,
  output logic [NUM_REQ-1:0]            req_rd_valid,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0]         out_wr_data,
  output logic                          out_wr,
  output logic                          out_rd,
  input  logic [DATA_WIDTH-1:0]         out_rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;
  // The WAIT counter counts down to zero, so it is loaded with one less than
  // the latency. A latency of zero never enters WAIT.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (READ_LATENCY > 0) ? CNT_W'(READ_LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETURN
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        last_grant_q;
  logic [IDX_W-1:0]        winner_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    op_wr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    out_wr_q;
  logic                    out_rd_q;
  logic [NUM_REQ-1:0]      rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q [NUM_REQ];

  // Per-requester views of the packed buses.
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]      pending;

  // Arbitration result for the current cycle.
  logic                    grant_found_d;
  logic [IDX_W-1:0]        winner_d;
  logic [IDX_W-1:0]        cand_idx;
  int                      cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wr_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign req_rd_data[g*DATA_WIDTH +: DATA_WIDTH] = rd_data_q[g];
  end

  assign pending = req_wr | req_rd;

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the combinational block infers a latch.
    grant_found_d = 1'b0;
    winner_d      = '0;
    cand          = 0;
    cand_idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_found_d && pending[cand_idx]) begin
        grant_found_d = 1'b1;
        winner_d      = cand_idx;
      end
    end
  end

  // Accept strobe to the winner, only while arbitrating in IDLE.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found_d) begin
      req_ready[winner_d] = 1'b1;
    end
  end

  // Transaction FSM with registered target strobes and read returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      winner_q     <= '0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      op_wr_q      <= 1'b0;
      cnt_q        <= '0;
      out_wr_q     <= 1'b0;
      out_rd_q     <= 1'b0;
      rd_valid_q   <= '0;
      // NOTE: the read-result array is a handful of registers that must read
      // as zero after reset, so it is cleared here rather than left as RAM.
      for (int i = 0; i < NUM_REQ; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the values from before this edge.
      out_wr_q   <= 1'b0;
      out_rd_q   <= 1'b0;
      rd_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_found_d) begin
            winner_q     <= winner_d;
            last_grant_q <= winner_d;
            addr_q       <= addr_arr[winner_d];
            wr_data_q    <= wdata_arr[winner_d];
            // A simultaneous write and read is served as the write only.
            op_wr_q      <= req_wr[winner_d];
            out_wr_q     <= req_wr[winner_d];
            out_rd_q     <= !req_wr[winner_d];
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_wr_q) begin
            state_q <= S_IDLE;
          end else if (READ_LATENCY == 0) begin
            rd_data_q[winner_q]  <= out_rd_data;
            rd_valid_q[winner_q] <= 1'b1;
            state_q              <= S_RETURN;
          end else begin
            cnt_q   <= CNT_LOAD;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rd_data_q[winner_q]  <= out_rd_data;
            rd_valid_q[winner_q] <= 1'b1;
            state_q              <= S_RETURN;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RETURN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign out_addr     = addr_q;
  assign out_wr_data  = wr_data_q;
  assign out_wr       = out_wr_q;
  assign out_rd       = out_rd_q;
  assign req_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// tb_bridge_arbiter
// Two arbiters: A (3 requesters, read latency 2) and B (2 requesters, read
// latency 0). Stimulus pushes the expected bus events into a per-DUT queue;
// a monitor per DUT pops and compares every event the DUT produces, including
// the cycle distance to the previous event.
module tb_bridge_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NA = 3;
  localparam int LA = 2;
  localparam int NB = 2;
  localparam int LB = 0;

  typedef enum int {EV_READY, EV_WR, EV_RD, EV_RVALID} ev_kind_e;

  typedef struct {
    ev_kind_e      kind;
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;   // cycles since previous event; -1 = don't care
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT A signals
  logic [NA*AW-1:0] a_req_addr;
  logic [NA*DW-1:0] a_req_wr_data;
  logic [NA-1:0]    a_req_wr, a_req_rd, a_req_ready, a_req_rd_valid;
  logic [NA*DW-1:0] a_req_rd_data;
  logic [AW-1:0]    a_out_addr;
  logic [DW-1:0]    a_out_wr_data, a_out_rd_data;
  logic             a_out_wr, a_out_rd;

  // DUT B signals
  logic [NB*AW-1:0] b_req_addr;
  logic [NB*DW-1:0] b_req_wr_data;
  logic [NB-1:0]    b_req_wr, b_req_rd, b_req_ready, b_req_rd_valid;
  logic [NB*DW-1:0] b_req_rd_data;
  logic [AW-1:0]    b_out_addr;
  logic [DW-1:0]    b_out_wr_data, b_out_rd_data;
  logic             b_out_wr, b_out_rd;

  bridge_arbiter #(.NUM_REQ(NA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LA)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_addr(a_req_addr), .req_wr_data(a_req_wr_data),
    .req_wr(a_req_wr), .req_rd(a_req_rd), .req_ready(a_req_ready),
    .req_rd_data(a_req_rd_data), .req_rd_valid(a_req_rd_valid),
    .out_addr(a_out_addr), .out_wr_data(a_out_wr_data),
    .out_wr(a_out_wr), .out_rd(a_out_rd), .out_rd_data(a_out_rd_data)
  );

  bridge_arbiter #(.NUM_REQ(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LB)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_addr(b_req_addr), .req_wr_data(b_req_wr_data),
    .req_wr(b_req_wr), .req_rd(b_req_rd), .req_ready(b_req_ready),
    .req_rd_data(b_req_rd_data), .req_rd_valid(b_req_rd_valid),
    .out_addr(b_out_addr), .out_wr_data(b_out_wr_data),
    .out_wr(b_out_wr), .out_rd(b_out_rd), .out_rd_data(b_out_rd_data)
  );

  // Target models: data is valid only in the cycle the arbiter must sample it.
  logic [DW-1:0] tgt_data_a = '0;
  logic [1:0]    rd_pipe_a  = '0;
  always @(posedge clk) rd_pipe_a <= {rd_pipe_a[0], a_out_rd};
  assign a_out_rd_data = rd_pipe_a[LA-1] ? tgt_data_a : 32'hBAD0BAD0;
  assign b_out_rd_data = b_out_rd ? 32'hA5A5A5A5 : 32'h0BAD0BAD;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  ev_t exp_a[$];
  ev_t exp_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic push(input bit on_b, input ev_kind_e kind, input int idx,
                      input logic [AW-1:0] addr, input logic [DW-1:0] data, input int gap);
    ev_t e;
    e.kind = kind; e.idx = idx; e.addr = addr; e.data = data; e.gap = gap;
    if (on_b) exp_b.push_back(e);
    else      exp_a.push_back(e);
  endtask

  task automatic compare_ev(input string tag, input ev_t e, input ev_t o);
    check({tag, "_kind"}, o.kind, e.kind);
    if (e.kind == EV_READY || e.kind == EV_RVALID) check({tag, "_idx"}, o.idx, e.idx);
    if (e.kind == EV_WR || e.kind == EV_RD)        check({tag, "_addr"}, o.addr, e.addr);
    if (e.kind == EV_WR || e.kind == EV_RVALID)    check({tag, "_data"}, o.data, e.data);
    if (e.gap >= 0)                                check({tag, "_gap"}, o.gap, e.gap);
  endtask

  // Monitor A: one event per cycle at most, compared against the queue.
  int last_a = 0;
  always @(negedge clk) begin : mon_a
    ev_t o;
    int  n;
    if (!reset) begin
      n = $countones(a_req_ready) + $countones(a_req_rd_valid) + int'(a_out_wr) + int'(a_out_rd);
      o.kind = EV_READY; o.idx = 0; o.addr = '0; o.data = '0; o.gap = 0;
      if (|a_req_ready) begin
        o.kind = EV_READY; o.idx = first_set(8'(a_req_ready));
      end else if (a_out_wr) begin
        o.kind = EV_WR; o.addr = a_out_addr; o.data = a_out_wr_data;
      end else if (a_out_rd) begin
        o.kind = EV_RD; o.addr = a_out_addr;
      end else if (|a_req_rd_valid) begin
        o.kind = EV_RVALID; o.idx = first_set(8'(a_req_rd_valid));
        o.data = a_req_rd_data[o.idx*DW +: DW];
      end
      if (n > 1) check("a_single_event_per_cycle", n, 1);
      if (n > 0) begin
        o.gap  = cyc - last_a;
        last_a = cyc;
        if (exp_a.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL a_unexpected_event: got kind %0d idx %0d addr 0x%0h, expected none (t=%0t)",
                   o.kind, o.idx, o.addr, $time);
        end else begin
          compare_ev("a", exp_a.pop_front(), o);
        end
      end
    end
  end

  // Monitor B: same checking for the zero-latency arbiter.
  int last_b = 0;
  always @(negedge clk) begin : mon_b
    ev_t o;
    int  n;
    if (!reset) begin
      n = $countones(b_req_ready) + $countones(b_req_rd_valid) + int'(b_out_wr) + int'(b_out_rd);
      o.kind = EV_READY; o.idx = 0; o.addr = '0; o.data = '0; o.gap = 0;
      if (|b_req_ready) begin
        o.kind = EV_READY; o.idx = first_set(8'(b_req_ready));
      end else if (b_out_wr) begin
        o.kind = EV_WR; o.addr = b_out_addr; o.data = b_out_wr_data;
      end else if (b_out_rd) begin
        o.kind = EV_RD; o.addr = b_out_addr;
      end else if (|b_req_rd_valid) begin
        o.kind = EV_RVALID; o.idx = first_set(8'(b_req_rd_valid));
        o.data = b_req_rd_data[o.idx*DW +: DW];
      end
      if (n > 1) check("b_single_event_per_cycle", n, 1);
      if (n > 0) begin
        o.gap  = cyc - last_b;
        last_b = cyc;
        if (exp_b.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b_unexpected_event: got kind %0d idx %0d addr 0x%0h, expected none (t=%0t)",
                   o.kind, o.idx, o.addr, $time);
        end else begin
          compare_ev("b", exp_b.pop_front(), o);
        end
      end
    end
  end

  task automatic drive_req(input bit on_b, input int i, input logic wr, input logic rd,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (on_b) begin
      b_req_addr[i*AW +: AW] = addr; b_req_wr_data[i*DW +: DW] = data;
      b_req_wr[i] = wr; b_req_rd[i] = rd;
    end else begin
      a_req_addr[i*AW +: AW] = addr; a_req_wr_data[i*DW +: DW] = data;
      a_req_wr[i] = wr; a_req_rd[i] = rd;
    end
  endtask

  task automatic wait_ready(input bit on_b, input int i, output int waited);
    logic r;
    waited = 0;
    r      = 1'b0;
    while (!r && waited < 200) begin
      @(negedge clk);
      waited++;
      r = on_b ? b_req_ready[i] : a_req_ready[i];
    end
    check(on_b ? "b_grant_wait" : "a_grant_wait", r, 1'b1);
  endtask

  // Hold a request for the given number of grants, then drop it the cycle after.
  task automatic request(input bit on_b, input int i, input logic wr, input logic rd,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data, input int grants);
    int w;
    drive_req(on_b, i, wr, rd, addr, data);
    for (int g = 0; g < grants; g++) wait_ready(on_b, i, w);
    @(posedge clk); #1;
    drive_req(on_b, i, 1'b0, 1'b0, addr, data);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && c < 100) begin
      @(posedge clk);
      c++;
    end
    check("scoreboard_drained", exp_a.size() + exp_b.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    reset = 1'b1;
    a_req_addr = '0; a_req_wr_data = '0; a_req_wr = '0; a_req_rd = '0;
    b_req_addr = '0; b_req_wr_data = '0; b_req_wr = '0; b_req_rd = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    check("a_rst_out_addr", a_out_addr, 0);
    check("a_rst_out_wr_data", a_out_wr_data, 0);
    check("a_rst_strobes", {a_out_wr, a_out_rd, a_req_ready, a_req_rd_valid}, 0);
    check("a_rst_rd_data", a_req_rd_data, 0);
    check("b_rst_out_addr", b_out_addr, 0);
    check("b_rst_strobes", {b_out_wr, b_out_rd, b_req_ready, b_req_rd_valid}, 0);
    check("b_rst_rd_data", b_req_rd_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // B: single write from requester 0
    push(1, EV_READY, 0, '0, '0, -1);
    push(1, EV_WR, 0, 32'h10, 32'hDEADBEEF, 1);
    request(1, 0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1);
    drain();
    check("b_addr_held_after_write", b_out_addr, 32'h10);

    // B: zero-latency read from requester 1
    push(1, EV_READY, 1, '0, '0, -1);
    push(1, EV_RD, 0, 32'h24, '0, 1);
    push(1, EV_RVALID, 1, '0, 32'hA5A5A5A5, 1);
    request(1, 1, 1'b0, 1'b1, 32'h24, 32'h0, 1);
    drain();
    check("b_rd_data1_held", b_req_rd_data[DW +: DW], 32'hA5A5A5A5);
    check("b_rd_data0_unchanged", b_req_rd_data[0 +: DW], 32'h0);

    // A: latency-2 read from requester 1
    tgt_data_a = 32'h12345678;
    push(0, EV_READY, 1, '0, '0, -1);
    push(0, EV_RD, 0, 32'h20, '0, 1);
    push(0, EV_RVALID, 1, '0, 32'h12345678, 3);
    request(0, 1, 1'b0, 1'b1, 32'h20, 32'h0, 1);
    drain();
    check("a_rd_data1_held", a_req_rd_data[DW +: DW], 32'h12345678);
    check("a_rd_data0_unchanged", a_req_rd_data[0 +: DW], 32'h0);

    // A: all three requesters hold writes; grants rotate 0,1,2,0,1,2
    do_reset();
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NA; i++) begin
        push(0, EV_READY, i, '0, '0, (r == 0 && i == 0) ? -1 : 1);
        push(0, EV_WR, 0, 32'h100 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 1);
      end
    end
    fork
      request(0, 0, 1'b1, 1'b0, 32'h100, 32'hC0DE0000, 2);
      request(0, 1, 1'b1, 1'b0, 32'h104, 32'hC0DE0001, 2);
      request(0, 2, 1'b1, 1'b0, 32'h108, 32'hC0DE0002, 2);
    join
    drain();

    // A: write and read held together: write first, then read same address
    tgt_data_a = 32'h0F0F0F0F;
    push(0, EV_READY, 0, '0, '0, -1);
    push(0, EV_WR, 0, 32'h40, 32'h55AA55AA, 1);
    push(0, EV_READY, 0, '0, '0, 1);
    push(0, EV_RD, 0, 32'h40, '0, 1);
    push(0, EV_RVALID, 0, '0, 32'h0F0F0F0F, 3);
    drive_req(0, 0, 1'b1, 1'b1, 32'h40, 32'h55AA55AA);
    wait_ready(0, 0, w);
    @(posedge clk); #1;
    a_req_wr[0] = 1'b0;
    wait_ready(0, 0, w);
    @(posedge clk); #1;
    a_req_rd[0] = 1'b0;
    drain();

    // A: reset asserted while a read from requester 2 sits in WAIT
    tgt_data_a = 32'h77777777;
    push(0, EV_READY, 2, '0, '0, -1);
    push(0, EV_RD, 0, 32'h30, '0, 1);
    drive_req(0, 2, 1'b0, 1'b1, 32'h30, 32'h0);
    wait_ready(0, 2, w);
    @(posedge clk); #1;
    a_req_rd[2] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("a_rst_midread_out_rd", a_out_rd, 1'b0);
    check("a_rst_midread_out_addr", a_out_addr, 0);
    check("a_rst_midread_rd_valid", a_req_rd_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("a_rst_midread_rd_data2", a_req_rd_data[2*DW +: DW], 32'h0);
    check("a_rst_midread_queue_empty", exp_a.size(), 0);

    // A: after reset requester 0 wins immediately over requester 2
    push(0, EV_READY, 0, '0, '0, -1);
    push(0, EV_WR, 0, 32'h50, 32'h11111111, 1);
    push(0, EV_READY, 2, '0, '0, 1);
    push(0, EV_WR, 0, 32'h58, 32'h22222222, 1);
    drive_req(0, 0, 1'b1, 1'b0, 32'h50, 32'h11111111);
    drive_req(0, 2, 1'b1, 1'b0, 32'h58, 32'h22222222);
    wait_ready(0, 0, w);
    check("a_post_reset_grant_latency", w, 1);
    @(posedge clk); #1;
    a_req_wr[0] = 1'b0;
    wait_ready(0, 2, w);
    @(posedge clk); #1;
    a_req_wr[2] = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
